ika2151_timer_array: RTL and testbench
======================================

# ika2151_timer_array

Parametrised timer unit for the IKA2151 core. It generalises the fixed Timer A/Timer B pair into NUM_TIMERS identical up-counting timers. Each timer has its own reload value, per-timer prescale, flag, IRQ enable and overflow strobe. It sits beside the register block: it consumes load/enable/flag-reset controls and frame strobes from there, and returns flags (status read), an open-drain-style IRQ and overflow strobes (CSM key-on).

## Interface
Parameters:
- NUM_TIMERS, 2, number of timer channels
- CNT_W, 10, counter/reload width
- PRESC_W, 4, per-timer prescaler width
- PRESC_LIST, {4'd15, 4'd0}, packed NUM_TIMERS×PRESC_W; timer k advances once every PRESC_LIST[k]+1 ticks (timer 0 = LSB slice)

Ports:
- i_EMUCLK  in  1  emulator master clock
- i_MRST_n  in  1  master reset, asynchronous, active-low
- i_phi1_PCEN_n  in  1  clock enable, active-low; state changes only on enabled edges
- i_CYCLE_31  in  1  frame tick; one tick = enabled edge with i_CYCLE_31=1
- i_TEST_FAST  in  1  test mode; bypasses all prescalers
- i_LOAD  in  NUM_TIMERS  run/load level per timer
- i_IRQEN  in  NUM_TIMERS  flag set enable per timer
- i_FRST  in  NUM_TIMERS  flag clear request, level, sampled on enabled edges
- i_VALUE  in  NUM_TIMERS×CNT_W  reload values, timer k at [k*CNT_W +: CNT_W]
- o_FLAG  out  NUM_TIMERS  sticky overflow flags
- o_OVFL  out  NUM_TIMERS  overflow strobe, one enabled cycle wide
- o_IRQ_n  out  1  ~|o_FLAG
- o_CNT  out  NUM_TIMERS×CNT_W  live counter values (debug/verification)

## Operation
- Per timer: CNT_W-bit counter, PRESC_W-bit prescaler, LOAD edge register, flag, overflow register.
- LOAD rising edge (sampled 0 then 1 on consecutive enabled edges): counter <= VALUE, prescaler <= 0, timer running.
- Running (LOAD=1): on each tick, prescaler increments. On prescaler == PRESC_LIST[k], or on any tick with i_TEST_FAST=1, prescaler <= 0 and the timer advances.
- Advance: if counter == all-ones, counter <= VALUE (the value current at that edge), OVFL=1 for that enabled cycle, and flag <= 1 if IRQEN=1. Otherwise counter+1.
- LOAD=0: counter and prescaler hold. OVFL=0. A later LOAD rise reloads.
- Flag: cleared on enabled edge with FRST=1. A simultaneous set and clear leaves the flag set.
- Clearing IRQEN does not clear an already set flag.
- VALUE changes while running take effect only at the next reload.
- VALUE = all-ones: overflow on every advance.
- Arithmetic is unsigned modulo 2^CNT_W. The prescaler compare is equality, so PRESC_LIST[k]=0 means advance every tick.

## Timing
- All registers update on the i_EMUCLK posedge with i_phi1_PCEN_n=0. Disabled edges hold all state.
- Reset (async assert, sync-to-clock deassert externally guaranteed): counters 0, prescalers 0, LOAD edge regs 0, o_FLAG 0, o_OVFL 0, o_IRQ_n 1.
- LOAD rise to counter=VALUE: visible after the enabled edge that samples LOAD=1.
- Overflow: o_CNT=VALUE, o_OVFL=1 and o_FLAG=1 all become visible after the same enabled edge. o_OVFL drops after the next enabled edge. o_IRQ_n is combinational from the flags, with no added latency.
- Reset asserted mid-count aborts immediately. After release, timers stay idle until a new LOAD rise; a LOAD already held high counts as a rise.

## Structure
- The shared package/include ika2151_pkg holds the IKA2151 defaults: TMR_CNT_W=10, TMR_PRESC_W=4, PRESC constants for A (0) and B (15).
- Sub-module ika2151_timer_ch contains one channel (counter, prescaler, edge detect, flag, strobe). It is generated NUM_TIMERS times. The top handles only slicing and the IRQ reduction.

## Test plan
- Reset, then hold LOAD=0 for 100 ticks → o_CNT all 0, o_FLAG=0, o_IRQ_n=1, no OVFL.
- Timer0 VALUE=1020, IRQEN=1, LOAD rise → OVFL on the 4th tick, flag set, IRQ_n=0, counter back to 1020. Repeats every 4 ticks.
- Timer1 PRESC=15, VALUE=1022 → overflow after 32 ticks. With i_TEST_FAST=1 → after 2 ticks.
- IRQEN=0 with overflow → OVFL pulses, flag stays 0. FRST asserted on the same edge as a set → flag remains 1. FRST on the next edge → flag 0, IRQ_n 1.
- Drop LOAD at count 1000, wait 50 ticks → count holds at 1000. Re-raise LOAD with VALUE=5 → counter=5.
- Assert i_MRST_n low while both timers are counting, with flags set → all outputs immediately return to their reset values.

Source files
------------

// File: rtl/ika2151_pkg.sv
// ika2151_pkg
//   Shared IKA2151 timer defaults: counter width, prescaler width and the
//   prescale constants of the original Timer A / Timer B pair.
package ika2151_pkg;

   localparam int unsigned TMR_NUM     = 2;
   localparam int unsigned TMR_CNT_W   = 10;
   localparam int unsigned TMR_PRESC_W = 4;

   // Timer A advances every tick, Timer B every 16 ticks.
   localparam logic [TMR_PRESC_W-1:0] TMR_PRESC_A = 4'd0;
   localparam logic [TMR_PRESC_W-1:0] TMR_PRESC_B = 4'd15;

endpackage

// File: rtl/ika2151_timer_array_if.sv
// ika2151_timer_array_if
//   Control/status bundle between the register block (master) and the
//   timer array (slave).
//     i_LOAD   run/load level per timer
//     i_IRQEN  flag set enable per timer
//     i_FRST   flag clear request per timer
//     i_VALUE  packed reload values, timer k at [k*CNT_W +: CNT_W]
//     o_FLAG   sticky overflow flags
//     o_OVFL   one-enabled-cycle overflow strobes
//     o_IRQ_n  active-low interrupt, ~|o_FLAG
//     o_CNT    packed live counter values
interface ika2151_timer_array_if #(
   parameter int unsigned NUM_TIMERS = 2,
   parameter int unsigned CNT_W      = 10
) ();

   logic [NUM_TIMERS-1:0]       i_LOAD;
   logic [NUM_TIMERS-1:0]       i_IRQEN;
   logic [NUM_TIMERS-1:0]       i_FRST;
   logic [NUM_TIMERS*CNT_W-1:0] i_VALUE;
   logic [NUM_TIMERS-1:0]       o_FLAG;
   logic [NUM_TIMERS-1:0]       o_OVFL;
   logic                        o_IRQ_n;
   logic [NUM_TIMERS*CNT_W-1:0] o_CNT;

   modport master (
      output i_LOAD, i_IRQEN, i_FRST, i_VALUE,
      input  o_FLAG, o_OVFL, o_IRQ_n, o_CNT
   );

   modport slave (
      input  i_LOAD, i_IRQEN, i_FRST, i_VALUE,
      output o_FLAG, o_OVFL, o_IRQ_n, o_CNT
   );

endinterface

// File: rtl/ika2151_timer_ch.sv
// ika2151_timer_ch
//   One up-counting timer channel: LOAD edge detect, prescaler, counter,
//   sticky flag and overflow strobe. All state moves only on enabled edges
//   (i_cen_n = 0); a tick is an enabled edge with i_cycle_31 = 1.
//     i_clk, i_rst_n   clock, async active-low reset
//     i_cen_n          active-low clock enable
//     i_cycle_31       frame tick qualifier
//     i_test_fast      bypass prescaler
//     i_load/i_irqen/i_frst/i_value   channel controls
//     o_flag/o_ovfl/o_cnt             channel status
module ika2151_timer_ch #(
   parameter int unsigned         CNT_W   = 10,
   parameter int unsigned         PRESC_W = 4,
   parameter logic [PRESC_W-1:0]  PRESC   = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_cen_n,
   input  logic             i_cycle_31,
   input  logic             i_test_fast,
   input  logic             i_load,
   input  logic             i_irqen,
   input  logic             i_frst,
   input  logic [CNT_W-1:0] i_value,
   output logic             o_flag,
   output logic             o_ovfl,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               load_q,  load_d;
   logic               flag_q,  flag_d;
   logic               ovfl_q,  ovfl_d;
   logic               flag_set;

   always_comb begin
      cnt_d    = cnt_q;
      presc_d  = presc_q;
      load_d   = load_q;
      flag_d   = flag_q;
      ovfl_d   = ovfl_q;
      flag_set = 1'b0;
      if (!i_cen_n) begin
         load_d = i_load;
         ovfl_d = 1'b0;
         // A LOAD rise reloads and wins over a coincident tick.
         if (i_load && !load_q) begin
            cnt_d   = i_value;
            presc_d = '0;
         end else if (i_load && i_cycle_31) begin
            if (i_test_fast || (presc_q == PRESC)) begin
               presc_d = '0;
               if (cnt_q == '1) begin
                  cnt_d    = i_value;
                  ovfl_d   = 1'b1;
                  flag_set = i_irqen;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         // Set has priority over a simultaneous clear.
         flag_d = flag_set | (flag_q & ~i_frst);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q   <= '0;
         presc_q <= '0;
         load_q  <= 1'b0;
         flag_q  <= 1'b0;
         ovfl_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         presc_q <= presc_d;
         load_q  <= load_d;
         flag_q  <= flag_d;
         ovfl_q  <= ovfl_d;
      end
   end

   assign o_cnt  = cnt_q;
   assign o_flag = flag_q;
   assign o_ovfl = ovfl_q;

endmodule

// File: rtl/ika2151_timer_array.sv
// ika2151_timer_array
//   NUM_TIMERS identical IKA2151 timers. Slices the packed bus into channels
//   and reduces the flags into the active-low IRQ.
//     i_EMUCLK        master clock
//     i_MRST_n        async active-low master reset
//     i_phi1_PCEN_n   active-low clock enable
//     i_CYCLE_31      frame tick qualifier
//     i_TEST_FAST     bypass all prescalers
//     tmr             control/status bundle (slave side)
module ika2151_timer_array
   import ika2151_pkg::*;
#(
   parameter int unsigned NUM_TIMERS = TMR_NUM,
   parameter int unsigned CNT_W      = TMR_CNT_W,
   parameter int unsigned PRESC_W    = TMR_PRESC_W,
   parameter logic [NUM_TIMERS*PRESC_W-1:0] PRESC_LIST = {TMR_PRESC_B, TMR_PRESC_A}
) (
   input  logic                i_EMUCLK,
   input  logic                i_MRST_n,
   input  logic                i_phi1_PCEN_n,
   input  logic                i_CYCLE_31,
   input  logic                i_TEST_FAST,
   ika2151_timer_array_if.slave tmr
);

   logic [NUM_TIMERS-1:0]       flag;
   logic [NUM_TIMERS-1:0]       ovfl;
   logic [NUM_TIMERS*CNT_W-1:0] cnt;

   for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_ch
      ika2151_timer_ch #(
         .CNT_W   (CNT_W),
         .PRESC_W (PRESC_W),
         .PRESC   (PRESC_LIST[k*PRESC_W +: PRESC_W])
      ) u_ch (
         .i_clk       (i_EMUCLK),
         .i_rst_n     (i_MRST_n),
         .i_cen_n     (i_phi1_PCEN_n),
         .i_cycle_31  (i_CYCLE_31),
         .i_test_fast (i_TEST_FAST),
         .i_load      (tmr.i_LOAD[k]),
         .i_irqen     (tmr.i_IRQEN[k]),
         .i_frst      (tmr.i_FRST[k]),
         .i_value     (tmr.i_VALUE[k*CNT_W +: CNT_W]),
         .o_flag      (flag[k]),
         .o_ovfl      (ovfl[k]),
         .o_cnt       (cnt[k*CNT_W +: CNT_W])
      );
   end

   assign tmr.o_FLAG  = flag;
   assign tmr.o_OVFL  = ovfl;
   assign tmr.o_CNT   = cnt;
   assign tmr.o_IRQ_n = ~|flag;

endmodule

// File: tb/tb_ika2151_timer_array.sv
module tb_ika2151_timer_array;

   logic clk = 1'b0;
   logic rst_n;
   logic pcen_n;
   logic cyc31;
   logic test_fast;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string       tag;
      int          kind;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];

   ika2151_timer_array_if #(.NUM_TIMERS(2), .CNT_W(10)) tif ();

   ika2151_timer_array #(
      .NUM_TIMERS (2),
      .CNT_W      (10),
      .PRESC_W    (4),
      .PRESC_LIST ({4'd15, 4'd0})
   ) dut (
      .i_EMUCLK      (clk),
      .i_MRST_n      (rst_n),
      .i_phi1_PCEN_n (pcen_n),
      .i_CYCLE_31    (cyc31),
      .i_TEST_FAST   (test_fast),
      .tmr           (tif)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] observe(input int kind);
      case (kind)
         0:       observe = {22'd0, tif.o_CNT[9:0]};
         1:       observe = {22'd0, tif.o_CNT[19:10]};
         2:       observe = {30'd0, tif.o_FLAG};
         3:       observe = {30'd0, tif.o_OVFL};
         default: observe = {31'd0, tif.o_IRQ_n};
      endcase
   endfunction

   task automatic push(input string tag, input int kind, input int unsigned v);
      exp_t e;
      e.tag  = tag;
      e.kind = kind;
      e.exp  = v;
      sb.push_back(e);
   endtask

   task automatic snap(input string tag, input int unsigned c0, input int unsigned c1,
                       input int unsigned fl, input int unsigned ov, input int unsigned irqn);
      push({tag, ".cnt0"},  0, c0);
      push({tag, ".cnt1"},  1, c1);
      push({tag, ".flag"},  2, fl);
      push({tag, ".ovfl"},  3, ov);
      push({tag, ".irq_n"}, 4, irqn);
   endtask

   task automatic drain();
      exp_t        e;
      logic [31:0] o;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = observe(e.kind);
         n_tests++;
         assert (o === e.exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.exp);
         end
      end
   endtask

   // One edge: inputs applied at negedge, outputs sampled 1 ns after posedge.
   task automatic step(input logic en_n, input logic cyc);
      @(negedge clk);
      pcen_n = en_n;
      cyc31  = cyc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n         = 1'b0;
      pcen_n        = 1'b1;
      cyc31         = 1'b0;
      test_fast     = 1'b0;
      tif.i_LOAD    = 2'b00;
      tif.i_IRQEN   = 2'b00;
      tif.i_FRST    = 2'b00;
      tif.i_VALUE   = '0;

      repeat (2) @(posedge clk);
      #1;
      snap("reset", 0, 0, 0, 0, 1);
      drain();
      @(negedge clk);
      rst_n = 1'b1;

      // Idle with LOAD low for 100 ticks.
      for (int i = 0; i < 100; i++) begin
         step(1'b0, 1'b1);
         push("idle.ovfl", 3, 0);
         drain();
      end
      snap("idle", 0, 0, 0, 0, 1);
      drain();

      // Timer 0: VALUE=1020, overflow every 4 ticks.
      tif.i_VALUE[9:0] = 10'd1020;
      tif.i_IRQEN      = 2'b01;
      tif.i_LOAD       = 2'b01;
      step(1'b0, 1'b0);
      snap("t0_load", 1020, 0, 0, 0, 1);
      drain();
      for (int t = 1; t <= 3; t++) begin
         step(1'b0, 1'b1);
         snap("t0_tick", 1020 + t, 0, 0, 0, 1);
         drain();
      end
      step(1'b0, 1'b1);
      snap("t0_ovfl", 1020, 0, 1, 1, 0);
      drain();
      step(1'b1, 1'b1);
      snap("t0_disabled_hold", 1020, 0, 1, 1, 0);
      drain();

      // New VALUE only applies at the next reload.
      tif.i_VALUE[9:0] = 10'd1010;
      for (int t = 1; t <= 3; t++) begin
         step(1'b0, 1'b1);
         snap("t0_rerun", 1020 + t, 0, 1, 0, 0);
         drain();
      end
      step(1'b0, 1'b1);
      snap("t0_ovfl2", 1010, 0, 1, 1, 0);
      drain();

      tif.i_LOAD = 2'b00;
      tif.i_FRST = 2'b01;
      step(1'b0, 1'b0);
      snap("t0_clr", 1010, 0, 0, 0, 1);
      drain();
      tif.i_FRST = 2'b00;

      // Timer 1: prescale 16, VALUE=1022, overflow after 32 ticks.
      tif.i_VALUE[19:10] = 10'd1022;
      tif.i_IRQEN        = 2'b10;
      tif.i_LOAD         = 2'b10;
      step(1'b0, 1'b0);
      snap("t1_load", 1010, 1022, 0, 0, 1);
      drain();
      for (int t = 1; t <= 31; t++) begin
         step(1'b0, 1'b1);
         snap("t1_tick", 1010, (t >= 16) ? 1023 : 1022, 0, 0, 1);
         drain();
      end
      step(1'b0, 1'b1);
      snap("t1_ovfl32", 1010, 1022, 2, 2, 0);
      drain();

      tif.i_FRST = 2'b10;
      step(1'b0, 1'b0);
      snap("t1_clr", 1010, 1022, 0, 0, 1);
      drain();
      tif.i_FRST = 2'b00;

      test_fast = 1'b1;
      step(1'b0, 1'b1);
      snap("t1_fast1", 1010, 1023, 0, 0, 1);
      drain();
      step(1'b0, 1'b1);
      snap("t1_fast_ovfl", 1010, 1022, 2, 2, 0);
      drain();

      // Clearing IRQEN keeps the flag; later overflows strobe without flag.
      tif.i_IRQEN = 2'b00;
      step(1'b0, 1'b0);
      snap("irqen_off_keep", 1010, 1022, 2, 0, 0);
      drain();
      tif.i_FRST = 2'b10;
      step(1'b0, 1'b0);
      snap("frst_clr", 1010, 1022, 0, 0, 1);
      drain();
      tif.i_FRST = 2'b00;
      step(1'b0, 1'b1);
      snap("noirq_tick", 1010, 1023, 0, 0, 1);
      drain();
      step(1'b0, 1'b1);
      snap("noirq_ovfl", 1010, 1022, 0, 2, 1);
      drain();

      // Simultaneous set and clear leaves the flag set.
      tif.i_IRQEN = 2'b10;
      step(1'b0, 1'b1);
      snap("setclr_pre", 1010, 1023, 0, 0, 1);
      drain();
      tif.i_FRST = 2'b10;
      step(1'b0, 1'b1);
      snap("setclr_same", 1010, 1022, 2, 2, 0);
      drain();
      step(1'b0, 1'b0);
      snap("setclr_next", 1010, 1022, 0, 0, 1);
      drain();
      tif.i_FRST = 2'b00;
      test_fast  = 1'b0;
      tif.i_LOAD = 2'b00;
      step(1'b0, 1'b0);
      snap("t1_stop", 1010, 1022, 0, 0, 1);
      drain();

      // Hold at 1000 with LOAD low, then reload to 5.
      tif.i_VALUE[9:0] = 10'd998;
      tif.i_IRQEN      = 2'b01;
      tif.i_LOAD       = 2'b01;
      step(1'b0, 1'b0);
      snap("hold_load", 998, 1022, 0, 0, 1);
      drain();
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      snap("hold_reach", 1000, 1022, 0, 0, 1);
      drain();
      tif.i_LOAD = 2'b00;
      for (int i = 0; i < 51; i++) begin
         step(1'b0, 1'b1);
         push("hold.cnt0", 0, 1000);
         push("hold.ovfl", 3, 0);
         drain();
      end
      tif.i_VALUE[9:0] = 10'd5;
      tif.i_LOAD       = 2'b01;
      step(1'b0, 1'b0);
      snap("reload5", 5, 1022, 0, 0, 1);
      drain();

      // Both timers at all-ones overflow on every advance, then async reset.
      tif.i_VALUE = {10'd1023, 10'd1023};
      tif.i_LOAD  = 2'b00;
      step(1'b0, 1'b0);
      snap("pre_both", 5, 1022, 0, 0, 1);
      drain();
      tif.i_LOAD  = 2'b11;
      tif.i_IRQEN = 2'b11;
      test_fast   = 1'b1;
      step(1'b0, 1'b0);
      snap("both_load", 1023, 1023, 0, 0, 1);
      drain();
      step(1'b0, 1'b1);
      snap("both_ovfl", 1023, 1023, 3, 3, 0);
      drain();
      step(1'b0, 1'b1);
      snap("both_ovfl_again", 1023, 1023, 3, 3, 0);
      drain();

      #2;
      rst_n = 1'b0;
      #1;
      snap("async_rst", 0, 0, 0, 0, 1);
      drain();
      step(1'b0, 1'b1);
      snap("rst_held", 0, 0, 0, 0, 1);
      drain();

      // LOAD held high through reset counts as a rise after release.
      rst_n = 1'b1;
      step(1'b0, 1'b0);
      snap("post_rst_rise", 1023, 1023, 0, 0, 1);
      drain();
      step(1'b0, 1'b1);
      snap("post_rst_ovfl", 1023, 1023, 3, 3, 0);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
